// File: rtl/dot_product_fp16_feeder.sv
// Serial-to-lane packer feeding the fp16 dot-product engine: builds L-lane a/b beats,
// frames vectors with first/last, and limits vectors awaiting an engine result.
module dot_product_fp16_feeder #(
    parameter  int B               = 2,
    parameter  int K               = 4,
    parameter  int FP              = 16,
    parameter  int MAX_OUTSTANDING = 16,
    localparam int L               = K * B,
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [FP-1:0]     i_a,
    input  logic [FP-1:0]     i_b,
    input  logic              i_last,
    output logic [L*FP-1:0]   o_a,
    output logic [L*FP-1:0]   o_b,
    output logic              o_first,
    output logic              o_last,
    input  logic              i_res_valid,
    output logic [OUT_W-1:0]  o_outstanding,
    output logic              o_err
);

    localparam int LANE_W = (L > 1) ? $clog2(L) : 1;

    typedef enum logic {
        IDLE,
        OPEN
    } state_t;

    state_t              state, state_next;
    logic [LANE_W-1:0]   lane, lane_next;
    logic [L*FP-1:0]     pack_a, pack_b, pack_a_next, pack_b_next;
    logic [L*FP-1:0]     beat_a, beat_b;
    logic                sent, sent_next;
    logic [OUT_W-1:0]    out_next;
    logic                accept, emit, inc, dec;
    logic                ready_next, err_next, first_next;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        accept      = i_valid && o_ready;
        beat_a      = pack_a;
        beat_b      = pack_b;
        beat_a[lane*FP +: FP] = i_a;
        beat_b[lane*FP +: FP] = i_b;
        emit        = accept && ((lane == LANE_W'(L - 1)) || i_last);

        state_next  = state;
        lane_next   = lane;
        pack_a_next = pack_a;
        pack_b_next = pack_b;
        sent_next   = sent;

        if (accept) begin
            state_next = i_last ? IDLE : OPEN;
            if (emit) begin
                // Clearing on emit makes the unfilled lanes of a partial beat +0.
                lane_next   = '0;
                pack_a_next = '0;
                pack_b_next = '0;
                sent_next   = !i_last;
            end else begin
                lane_next   = lane + 1'b1;
                pack_a_next = beat_a;
                pack_b_next = beat_b;
            end
        end

        // sent marks that this vector already produced a beat, so the next one is not first.
        first_next = emit && !sent;

        inc      = emit && i_last;
        dec      = i_res_valid && (o_outstanding != '0);
        out_next = o_outstanding;
        if (inc && !dec) begin
            out_next = o_outstanding + 1'b1;
        end else if (!inc && dec) begin
            out_next = o_outstanding - 1'b1;
        end

        err_next   = o_err || (i_res_valid && (o_outstanding == '0));
        // Only a new vector is held off by the credit limit; an open one always completes.
        ready_next = !((state_next == IDLE) && (lane_next == '0) &&
                       (out_next == OUT_W'(MAX_OUTSTANDING)));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            lane          <= '0;
            pack_a        <= '0;
            pack_b        <= '0;
            sent          <= 1'b0;
            o_ready       <= 1'b0;
            o_a           <= '0;
            o_b           <= '0;
            o_first       <= 1'b0;
            o_last        <= 1'b0;
            o_outstanding <= '0;
            o_err         <= 1'b0;
        end else begin
            state         <= state_next;
            lane          <= lane_next;
            pack_a        <= pack_a_next;
            pack_b        <= pack_b_next;
            sent          <= sent_next;
            o_ready       <= ready_next;
            o_a           <= emit ? beat_a : '0;
            o_b           <= emit ? beat_b : '0;
            o_first       <= first_next;
            o_last        <= inc;
            o_outstanding <= out_next;
            o_err         <= err_next;
        end
    end

endmodule

// File: tb/tb_dot_product_fp16_feeder.sv
// Directed bench for dot_product_fp16_feeder: framing, zero padding, credit limit,
// spurious-result error and reset behaviour, with hand-computed expected beats.
module tb_dot_product_fp16_feeder;

    localparam int L  = 8;
    localparam int FP = 16;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [FP-1:0]   i_a = '0;
    logic [FP-1:0]   i_b = '0;
    logic            i_last = 1'b0;
    logic [L*FP-1:0] o_a;
    logic [L*FP-1:0] o_b;
    logic            o_first;
    logic            o_last;
    logic            i_res_valid = 1'b0;
    logic [4:0]      o_outstanding;
    logic            o_err;

    int errors = 0;
    int checks = 0;

    dot_product_fp16_feeder #(
        .B(2), .K(4), .FP(16), .MAX_OUTSTANDING(16)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_a(i_a),
        .i_b(i_b),
        .i_last(i_last),
        .o_a(o_a),
        .o_b(o_b),
        .o_first(o_first),
        .o_last(o_last),
        .i_res_valid(i_res_valid),
        .o_outstanding(o_outstanding),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_pair(input logic [FP-1:0] a, input logic [FP-1:0] b, input logic last);
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_last  = last;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic result_pulse();
        i_res_valid = 1'b1;
        tick();
        i_res_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        checks++;
        if (o_ready !== 1'b0 || o_a !== '0 || o_b !== '0 || o_first !== 1'b0 ||
            o_last !== 1'b0 || o_outstanding !== 5'd0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b first=%b last=%b out=%0d err=%b a=%h (want all 0)",
                     o_ready, o_first, o_last, o_outstanding, o_err, o_a);
        end
        i_reset = 1'b0;
        tick();
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", o_ready);
        end
    endtask

    task automatic test_full_vector();
        logic [L*FP-1:0] exp_a, exp_b;
        int zero_cycles;
        exp_a = {L{16'h3C00}};
        exp_b = {L{16'h4000}};
        zero_cycles = 0;
        for (int i = 0; i < 8; i++) send_pair(16'h3C00, 16'h4000, 1'b0);
        checks++;
        if (o_a !== exp_a || o_b !== exp_b || o_first !== 1'b1 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL full_beat1: a=%h b=%h first=%b last=%b want a=%h b=%h first=1 last=0",
                     o_a, o_b, o_first, o_last, exp_a, exp_b);
        end
        for (int i = 8; i < 15; i++) begin
            send_pair(16'h3C00, 16'h4000, 1'b0);
            if (o_a === '0 && o_b === '0 && o_first === 1'b0 && o_last === 1'b0) zero_cycles++;
        end
        checks++;
        if (zero_cycles !== 7) begin
            errors++;
            $display("FAIL full_gap: zero cycles got %0d want 7", zero_cycles);
        end
        send_pair(16'h3C00, 16'h4000, 1'b1);
        checks++;
        if (o_a !== exp_a || o_b !== exp_b || o_first !== 1'b0 || o_last !== 1'b1 ||
            o_outstanding !== 5'd1) begin
            errors++;
            $display("FAIL full_beat2: a=%h first=%b last=%b out=%0d want first=0 last=1 out=1",
                     o_a, o_first, o_last, o_outstanding);
        end
        tick();
        checks++;
        if (o_a !== '0 || o_last !== 1'b0 || o_outstanding !== 5'd1) begin
            errors++;
            $display("FAIL full_after: a=%h last=%b out=%0d want 0/0/1", o_a, o_last, o_outstanding);
        end
        result_pulse();
        checks++;
        if (o_outstanding !== 5'd0) begin
            errors++;
            $display("FAIL full_release: out got %0d want 0", o_outstanding);
        end
    endtask

    task automatic test_partial();
        logic [L*FP-1:0] exp_a, exp_b;
        exp_a = {80'h0, 16'h3333, 16'h2222, 16'h1111};
        exp_b = {80'h0, 16'h6666, 16'h5555, 16'h4444};
        send_pair(16'h1111, 16'h4444, 1'b0);
        send_pair(16'h2222, 16'h5555, 1'b0);
        send_pair(16'h3333, 16'h6666, 1'b1);
        checks++;
        if (o_a !== exp_a || o_b !== exp_b || o_first !== 1'b1 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL partial_beat: a=%h b=%h first=%b last=%b want a=%h b=%h 1/1",
                     o_a, o_b, o_first, o_last, exp_a, exp_b);
        end
        result_pulse();
    endtask

    task automatic test_single();
        logic [L*FP-1:0] exp_a, exp_b;
        exp_a = {112'h0, 16'h4200};
        exp_b = {112'h0, 16'h3800};
        send_pair(16'h4200, 16'h3800, 1'b1);
        checks++;
        if (o_a !== exp_a || o_b !== exp_b || o_first !== 1'b1 || o_last !== 1'b1 ||
            o_outstanding !== 5'd1) begin
            errors++;
            $display("FAIL single_beat: a=%h b=%h first=%b last=%b out=%0d want a=%h b=%h 1/1 out=1",
                     o_a, o_b, o_first, o_last, o_outstanding, exp_a, exp_b);
        end
        result_pulse();
    endtask

    task automatic test_credit_limit();
        for (int i = 0; i < 15; i++) send_pair(16'(i + 1), 16'h3C00, 1'b1);
        checks++;
        if (o_outstanding !== 5'd15 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL credit_15: out=%0d ready=%b want 15/1", o_outstanding, o_ready);
        end
        send_pair(16'h0010, 16'h3C00, 1'b1);
        checks++;
        if (o_outstanding !== 5'd16 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL credit_16: out=%0d ready=%b want 16/0", o_outstanding, o_ready);
        end
        send_pair(16'h0011, 16'h3C00, 1'b1);
        checks++;
        if (o_outstanding !== 5'd16 || o_first !== 1'b0 || o_a !== '0) begin
            errors++;
            $display("FAIL credit_ignored: out=%0d first=%b a=%h want 16/0/0",
                     o_outstanding, o_first, o_a);
        end
        result_pulse();
        checks++;
        if (o_outstanding !== 5'd15 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL credit_release: out=%0d ready=%b want 15/1", o_outstanding, o_ready);
        end
        i_res_valid = 1'b1;
        send_pair(16'h0012, 16'h3C00, 1'b1);
        i_res_valid = 1'b0;
        checks++;
        if (o_last !== 1'b1 || o_outstanding !== 5'd15) begin
            errors++;
            $display("FAIL credit_simul: last=%b out=%0d want 1/15", o_last, o_outstanding);
        end
        i_res_valid = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        i_res_valid = 1'b0;
        checks++;
        if (o_outstanding !== 5'd0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL credit_drain: out=%0d err=%b want 0/0", o_outstanding, o_err);
        end
    endtask

    task automatic test_spurious();
        result_pulse();
        checks++;
        if (o_err !== 1'b1 || o_outstanding !== 5'd0) begin
            errors++;
            $display("FAIL spurious_set: err=%b out=%0d want 1/0", o_err, o_outstanding);
        end
        tick();
        tick();
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL spurious_sticky: err=%b want 1", o_err);
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL spurious_clear: err=%b want 0", o_err);
        end
        tick();
    endtask

    task automatic test_reset_mid_vector();
        int beats;
        logic [L*FP-1:0] exp_a;
        exp_a = {16'h3C08, 16'h3C07, 16'h3C06, 16'h3C05, 16'h3C04, 16'h3C03, 16'h3C02, 16'h3C01};
        beats = 0;
        for (int i = 0; i < 5; i++) begin
            send_pair(16'h4400, 16'h4400, 1'b0);
            if (o_first === 1'b1 || o_last === 1'b1 || o_a !== '0) beats++;
        end
        i_reset = 1'b1;
        tick();
        if (o_first === 1'b1 || o_last === 1'b1 || o_a !== '0) beats++;
        checks++;
        if (beats !== 0 || o_b !== '0 || o_outstanding !== 5'd0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: beats=%0d b=%h out=%0d ready=%b want 0/0/0/0",
                     beats, o_b, o_outstanding, o_ready);
        end
        i_reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            send_pair(16'(16'h3C01 + i), 16'h3C00, (i == 7));
            if (o_first === 1'b1 || o_last === 1'b1) beats++;
            if (i == 7) begin
                checks++;
                if (o_a !== exp_a || o_first !== 1'b1 || o_last !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_beat: a=%h first=%b last=%b want a=%h 1/1",
                             o_a, o_first, o_last, exp_a);
                end
            end
        end
        tick();
        if (o_first === 1'b1 || o_last === 1'b1) beats++;
        checks++;
        if (beats !== 1) begin
            errors++;
            $display("FAIL midreset_count: beats got %0d want 1", beats);
        end
        result_pulse();
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_partial();
        test_single();
        test_credit_limit();
        test_spurious();
        test_reset_mid_vector();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
